// File: rtl/pe_mem_pkg.sv
// Shared definitions for the PE-array write-back path.
//
// Contents:
//   SIZE, DATA_W, ACC_W, ADDR_W : default frame / width constants
//   state_t                     : write-back controller states
//   sat_t                       : result of the ReLU + clamp transform
//   sat_result()                : ReLU + signed saturation to data_w bits
//
// sat_result works on 64-bit signed containers so that one function serves
// any instance width with ACC_W <= 64. The caller keeps the low data_w bits
// of the returned value.
package pe_mem_pkg;

    localparam int SIZE   = 224;
    localparam int DATA_W = 32;
    localparam int ACC_W  = 48;
    localparam int ADDR_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic               clamped;
        logic signed [63:0] value;
    } sat_t;

    // ReLU first (a ReLU zero is not a clamp), then clamp to the signed
    // range of data_w bits.
    function automatic sat_t sat_result(input logic signed [63:0] value,
                                        input logic               relu,
                                        input int                 data_w);
        sat_t               r;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v     = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        min_v     = -(64'sd1 <<< (data_w - 1));
        r.clamped = 1'b0;
        r.value   = value;
        if (relu && (value < 64'sd0)) begin
            r.value = 64'sd0;
        end else if (value > max_v) begin
            r.value   = max_v;
            r.clamped = 1'b1;
        end else if (value < min_v) begin
            r.value   = min_v;
            r.clamped = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry synchronous FIFO of {addr, data} pairs.
//
// Ports:
//   clk, rst               : clock, synchronous active-high flush
//   push, push_addr/data   : write one entry (ignored when full unless a
//                            pop happens in the same cycle)
//   pop                    : remove the head entry (ignored when empty)
//   count                  : number of valid entries (0..2)
//   head_addr, head_data   : oldest entry, valid when count != 0
module wb_fifo2 #(
    parameter int AW = 16,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [1:0]    count,
    output logic [AW-1:0] head_addr,
    output logic [DW-1:0] head_data
);

    localparam int EW = AW + DW;

    logic [EW-1:0] entry_reg [2];
    logic          wr_ptr_reg;
    logic          rd_ptr_reg;
    logic [1:0]    count_reg;
    logic          push_eff;
    logic          pop_eff;

    assign pop_eff  = pop && (count_reg != 2'd0);
    // A simultaneous pop frees a slot, so a full FIFO may still take a push.
    assign push_eff = push && ((count_reg != 2'd2) || pop_eff);

    always_ff @(posedge clk) begin
        if (rst) begin
            entry_reg[0] <= '0;
            entry_reg[1] <= '0;
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
            count_reg    <= 2'd0;
        end else begin
            if (push_eff) begin
                entry_reg[wr_ptr_reg] <= {push_addr, push_data};
                wr_ptr_reg            <= ~wr_ptr_reg;
            end
            if (pop_eff) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({push_eff, pop_eff})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign count                  = count_reg;
    assign {head_addr, head_data} = entry_reg[rd_ptr_reg];

endmodule

// File: rtl/pe_result_writeback.sv
// Write-back end of the PE-array -> main-memory path.
//
// Accepts one accumulated result per output pixel in raster order, applies
// optional ReLU and saturation to DATA_W, and writes it to memory at
// base_addr + pixel_index (wrapping modulo 2^ADDR_W). A two-entry FIFO
// absorbs memory back-pressure; done pulses once the last word of the
// SIZE x SIZE frame has been accepted by memory.
//
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   start                 : frame start pulse (honoured only when idle)
//   base_addr, relu_en    : frame settings, captured on accepted start
//   res_valid/ready/data  : PE result stream (ready is register-driven)
//   mem_we/ready/addr/wdata : memory write request stream
//   busy                  : frame in progress (RUN, DRAIN, DONE)
//   done                  : one-cycle pulse after the final write
//   sat_count             : clamped results this frame, sticky at 16'hFFFF
module pe_result_writeback #(
    parameter int SIZE   = pe_mem_pkg::SIZE,
    parameter int DATA_W = pe_mem_pkg::DATA_W,
    parameter int ACC_W  = pe_mem_pkg::ACC_W,
    parameter int ADDR_W = pe_mem_pkg::ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic                    relu_en,
    input  logic                    res_valid,
    output logic                    res_ready,
    input  logic signed [ACC_W-1:0] res_data,
    output logic                    mem_we,
    input  logic                    mem_ready,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    output logic                    busy,
    output logic                    done,
    output logic [15:0]             sat_count
);

    import pe_mem_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_P = ADDR_W'(SIZE * SIZE - 1);

    state_t              state_reg;
    state_t              state_next;
    logic [ADDR_W-1:0]   base_reg;
    logic [ADDR_W-1:0]   p_reg;
    logic                relu_reg;
    logic [15:0]         sat_count_reg;

    logic                accept;
    logic                pop;
    logic [1:0]          fifo_count;
    logic [ADDR_W-1:0]   head_addr;
    logic [DATA_W-1:0]   head_data;
    logic [ADDR_W-1:0]   push_addr;
    logic [DATA_W-1:0]   push_data;
    logic signed [63:0]  res_ext;
    sat_t                sat;
    logic                unused_sat_hi;

    assign accept = res_valid && res_ready;
    assign pop    = mem_we && mem_ready;

    // Transform of the incoming result
    assign res_ext   = 64'(res_data);
    assign sat       = sat_result(res_ext, relu_reg, DATA_W);
    assign push_data = sat.value[DATA_W-1:0];
    // Upper bits are sign extension of an in-range value.
    assign unused_sat_hi = ^sat.value[63:DATA_W];
    assign push_addr = base_reg + p_reg;

    wb_fifo2 #(
        .AW (ADDR_W),
        .DW (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_addr (push_addr),
        .push_data (push_data),
        .pop       (pop),
        .count     (fifo_count),
        .head_addr (head_addr),
        .head_data (head_data)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept && (p_reg == LAST_P)) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Leave as soon as the last entry is being handshaken so
                // done follows the final write by exactly one cycle.
                if ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output logic: everything here derives from registers only.
    always_comb begin
        res_ready = (state_reg == ST_RUN) && (fifo_count != 2'd2);
        busy      = (state_reg != ST_IDLE);
        done      = (state_reg == ST_DONE);
    end

    // Frame settings, pixel counter and saturation counter
    always_ff @(posedge clk) begin
        if (rst) begin
            base_reg      <= '0;
            p_reg         <= '0;
            relu_reg      <= 1'b0;
            sat_count_reg <= 16'd0;
        end else if ((state_reg == ST_IDLE) && start) begin
            base_reg      <= base_addr;
            relu_reg      <= relu_en;
            p_reg         <= '0;
            sat_count_reg <= 16'd0;
        end else if (accept) begin
            p_reg <= p_reg + 1'b1;
            if (sat.clamped && (sat_count_reg != 16'hFFFF)) begin
                sat_count_reg <= sat_count_reg + 16'd1;
            end
        end
    end

    // An empty FIFO presents zeros rather than stale entries.
    assign mem_we    = (fifo_count != 2'd0);
    assign mem_addr  = mem_we ? head_addr : '0;
    assign mem_wdata = mem_we ? head_data : '0;
    assign sat_count = sat_count_reg;

endmodule

// File: tb/tb_pe_result_writeback.sv
module tb_pe_result_writeback;

    localparam int SIZE   = 4;
    localparam int DATA_W = 32;
    localparam int ACC_W  = 48;
    localparam int ADDR_W = 16;
    localparam int NPIX   = SIZE * SIZE;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    start = 1'b0;
    logic [ADDR_W-1:0]       base_addr = '0;
    logic                    relu_en = 1'b0;
    logic                    res_valid = 1'b0;
    logic                    res_ready;
    logic signed [ACC_W-1:0] res_data = '0;
    logic                    mem_we;
    logic                    mem_ready = 1'b1;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_wdata;
    logic                    busy;
    logic                    done;
    logic [15:0]             sat_count;

    pe_result_writeback #(
        .SIZE   (SIZE),
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .relu_en   (relu_en),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .mem_we    (mem_we),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .sat_count (sat_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    wr_t               expq[$];
    int                phase = 0;      // 0 idle, 1 run, 2 drain, 3 done
    logic [ADDR_W-1:0] m_base = '0;
    bit                m_relu = 1'b0;
    int                m_p = 0;
    int                m_sat = 0;
    bit                live = 1'b0;
    bit                after_rst = 1'b0;
    bit                prev_stall = 1'b0;
    logic [ADDR_W-1:0] prev_a = '0;
    logic [DATA_W-1:0] prev_d = '0;

    logic [ADDR_W-1:0] log_a [512];
    logic [DATA_W-1:0] log_d [512];
    int                log_n = 0;

    function automatic wr_t model_xform(input longint v, input bit relu, input logic [ADDR_W-1:0] base,
                                        input int p, output bit clamped);
        wr_t    w;
        longint r;
        clamped = 1'b0;
        r = v;
        if (relu && v < 0) r = 0;
        else if (v > 64'sd2147483647) begin r = 64'sd2147483647; clamped = 1'b1; end
        else if (v < -64'sd2147483648) begin r = -64'sd2147483648; clamped = 1'b1; end
        w.a = ADDR_W'(base + ADDR_W'(p));
        w.d = DATA_W'(r);
        return w;
    endfunction

    initial begin
        forever begin
            bit  acc;
            bit  cl;
            wr_t w;
            @(negedge clk);
            if (rst) begin
                phase = 0; expq.delete(); m_sat = 0; m_p = 0;
                live = 1'b1; after_rst = 1'b1; prev_stall = 1'b0;
                continue;
            end
            if (!live) continue;
            if (after_rst) begin
                chk("rst_res_ready", res_ready, 0);
                chk("rst_mem_we", mem_we, 0);
                chk("rst_mem_addr", mem_addr, 0);
                chk("rst_mem_wdata", mem_wdata, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_sat_count", sat_count, 0);
                after_rst = 1'b0;
            end
            chk("mem_we", mem_we, expq.size() > 0);
            chk("res_ready", res_ready, (phase == 1) && (expq.size() < 2));
            chk("busy", busy, phase != 0);
            chk("done", done, phase == 3);
            chk("sat_count", sat_count, 64'(m_sat));
            if (prev_stall) begin
                chk("stall_addr_stable", mem_addr, prev_a);
                chk("stall_data_stable", mem_wdata, prev_d);
            end
            if (mem_we && expq.size() > 0) begin
                chk("mem_addr", mem_addr, expq[0].a);
                chk("mem_wdata", mem_wdata, expq[0].d);
            end
            prev_stall = mem_we && !mem_ready;
            prev_a = mem_addr;
            prev_d = mem_wdata;
            acc = res_valid && (phase == 1) && (expq.size() < 2);
            if (mem_we && mem_ready) begin
                $display("write addr=%04h data=%08h", mem_addr, mem_wdata);
                log_a[log_n] = mem_addr;
                log_d[log_n] = mem_wdata;
                log_n++;
                if (expq.size() > 0) void'(expq.pop_front());
            end
            if (acc) begin
                w = model_xform(longint'(res_data), m_relu, m_base, m_p, cl);
                expq.push_back(w);
                if (cl && m_sat < 65535) m_sat++;
                m_p++;
            end
            case (phase)
                0: if (start) begin
                    phase = 1; m_base = base_addr; m_relu = relu_en; m_p = 0; m_sat = 0;
                end
                1: if (acc && m_p == NPIX) phase = 2;
                2: if (expq.size() == 0) phase = 3;
                default: phase = 0;
            endcase
        end
    end

    // ---------------- stimulus ----------------
    longint frame_vals [NPIX];

    task automatic run_frame(input logic [ADDR_W-1:0] base, input bit relu,
                             input int stall_at, input int stall_len, input int abort_n,
                             input bit start_mid,
                             output int first, output int nwr, output int ndone);
        int i = 0;
        int cyc = 0;
        int post = 0;
        ndone = 0;
        first = log_n;
        @(posedge clk); #1;
        start = 1'b1; base_addr = base; relu_en = relu;
        forever begin
            @(posedge clk); #1;
            start = 1'b0;
            base_addr = 16'hDEAD;
            relu_en = ~relu;
            mem_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            if (start_mid && cyc == 3) begin
                start = 1'b1;
                base_addr = 16'h5555;
            end
            if (abort_n >= 0 && i == abort_n) begin
                rst = 1'b1; res_valid = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0; mem_ready = 1'b1;
                repeat (4) @(posedge clk);
                #1;
                break;
            end
            res_valid = (i < NPIX);
            res_data  = 48'(frame_vals[(i < NPIX) ? i : 0]);
            @(negedge clk);
            if (stall_len > 0 && cyc == stall_at + stall_len - 1) begin
                chk("bp_ready_low", res_ready, 0);
                chk("bp_we_held", mem_we, 1);
            end
            if (res_valid && res_ready) i++;
            if (done) ndone++;
            if (ndone > 0) post++;
            if (post >= 3) break;
            cyc++;
            if (cyc > 200) begin
                chk("frame_timeout", 1, 0);
                break;
            end
        end
        res_valid = 1'b0;
        mem_ready = 1'b1;
        nwr = log_n - first;
    endtask

    initial begin
        int f, nw, nd;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // 1: plain frame, data = pixel index
        for (int k = 0; k < NPIX; k++) frame_vals[k] = k;
        run_frame(16'd100, 1'b0, 1000, 0, -1, 1'b0, f, nw, nd);
        chk("f1_writes", nw, 16);
        chk("f1_done_pulses", nd, 1);
        chk("f1_first_addr", log_a[f], 100);
        chk("f1_first_data", log_d[f], 0);
        chk("f1_last_addr", log_a[f+15], 115);
        chk("f1_last_data", log_d[f+15], 15);
        chk("f1_sat", sat_count, 0);

        // 2: saturation without ReLU
        for (int k = 0; k < NPIX; k++) frame_vals[k] = k;
        frame_vals[0] = 64'sd1 <<< 40;
        frame_vals[1] = -(64'sd1 <<< 40);
        frame_vals[2] = -5;
        run_frame(16'd0, 1'b0, 1000, 0, -1, 1'b0, f, nw, nd);
        chk("sat_w0", log_d[f], 32'h7FFFFFFF);
        chk("sat_w1", log_d[f+1], 32'h80000000);
        chk("sat_w2", log_d[f+2], 32'hFFFFFFFB);
        chk("sat_count2", sat_count, 2);

        // 3: same inputs with ReLU
        run_frame(16'd0, 1'b1, 1000, 0, -1, 1'b0, f, nw, nd);
        chk("relu_w0", log_d[f], 32'h7FFFFFFF);
        chk("relu_w1", log_d[f+1], 0);
        chk("relu_w2", log_d[f+2], 0);
        chk("relu_sat1", sat_count, 1);

        // 4: back-pressure for 5 cycles mid-frame
        for (int k = 0; k < NPIX; k++) frame_vals[k] = k * 3 - 20;
        run_frame(16'd200, 1'b0, 5, 5, -1, 1'b0, f, nw, nd);
        chk("bp_writes", nw, 16);
        chk("bp_done_pulses", nd, 1);
        chk("bp_w7_addr", log_a[f+7], 207);
        chk("bp_w7_data", log_d[f+7], 32'd1);

        // 5: address wrap
        for (int k = 0; k < NPIX; k++) frame_vals[k] = k;
        run_frame(16'hFFFE, 1'b0, 1000, 0, -1, 1'b0, f, nw, nd);
        chk("wrap_a0", log_a[f], 16'hFFFE);
        chk("wrap_a1", log_a[f+1], 16'hFFFF);
        chk("wrap_a2", log_a[f+2], 16'h0000);
        chk("wrap_a3", log_a[f+3], 16'h0001);

        // 6: reset after 5 accepts, then a clean frame
        run_frame(16'd40, 1'b0, 1000, 0, 5, 1'b0, f, nw, nd);
        chk("abort_done_pulses", nd, 0);
        run_frame(16'd300, 1'b0, 1000, 0, -1, 1'b0, f, nw, nd);
        chk("post_rst_writes", nw, 16);
        chk("post_rst_first_addr", log_a[f], 300);
        chk("post_rst_first_data", log_d[f], 0);

        // 7: start during RUN must be ignored
        run_frame(16'd50, 1'b0, 1000, 0, -1, 1'b1, f, nw, nd);
        chk("smid_writes", nw, 16);
        chk("smid_done_pulses", nd, 1);
        chk("smid_last_addr", log_a[f+15], 65);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_result_writeback.md
Name: pe_result_writeback

Overview:
- Write-back end of the main-memory/PE-array path: accepts one accumulated result per output pixel from the PE array in raster order.
- Applies optional ReLU and saturates each result to DATA_W.
- Writes results into main memory at base_addr + row*SIZE + col.
- Buffers up to two results so memory back-pressure never drops data; signals done when the full SIZE x SIZE frame is committed.

Parameters:
- SIZE, 224, output frame is SIZE x SIZE pixels
- DATA_W, 32, memory word width (signed)
- ACC_W, 48, PE accumulator result width (signed), ACC_W > DATA_W
- ADDR_W, 16, memory word address width, must satisfy 2^ADDR_W >= SIZE*SIZE

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a frame
- base_addr  in  ADDR_W  frame base word address, sampled on accepted start
- relu_en  in  1  clamp negatives to 0, sampled on accepted start
- res_valid  in  1  PE result valid
- res_ready  out  1  block accepts result this cycle
- res_data  in  ACC_W  signed PE result
- mem_we  out  1  write request valid
- mem_ready  in  1  memory accepts write this cycle
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  DATA_W  write data
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse, last word committed
- sat_count  out  16  results clamped this frame, sticky at 16'hFFFF

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state IDLE; FIFO flushed; pixel counter 0.
  - All outputs 0: res_ready, mem_we, mem_addr, mem_wdata, busy, done, sat_count.
  - Reset mid-frame abandons the frame; no further mem_we; no done.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start=1 -> latch base_addr and relu_en, clear pixel counter and sat_count, go RUN.
  - RUN: a result is accepted when res_valid && res_ready. Acceptance of pixel SIZE*SIZE-1 -> DRAIN.
  - DRAIN: res_ready=0; stay until FIFO is empty (last write handshaken) -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
  - busy=1 in RUN, DRAIN and DONE.
  - start outside IDLE is ignored.
- res_ready = (state==RUN) && (fifo_count<2). Registered only; no combinational path from mem_ready or res_valid.
- Transform on accept, applied in this order:
  - If relu_en and res_data<0: value = 0.
  - Else if value > 2^(DATA_W-1)-1: clamp to max.
  - Else if value < -2^(DATA_W-1): clamp to min.
  - sat_count increments only on a clamp; a ReLU zero is not counted.
- Address: linear pixel counter p (0..SIZE*SIZE-1), increments by 1 per accepted result; addr = base_addr + p, modulo 2^ADDR_W (wrap allowed, no error).
- FIFO: 2 entries of {addr, data}.
  - mem_we = fifo not empty; mem_addr/mem_wdata = head entry.
  - Pop on mem_we && mem_ready.
  - Push and pop in the same cycle keep the count unchanged.
  - Entries are written in acceptance order; no write is duplicated or skipped.
- Latency: result accepted at edge t -> mem_we=1 with that data from edge t (registered output, visible the following cycle). Full throughput of 1 word/cycle when mem_ready is held 1.
- mem_ready=0 holds mem_we, mem_addr and mem_wdata stable until accepted.

Decomposition:
- Shared package (pe_mem_pkg): SIZE, DATA_W, ACC_W, ADDR_W constants; state enum typedef; a sat_result function (ReLU + clamp, returns value and clamp flag).
- Sub-module: wb_fifo2 (2-entry synchronous FIFO with count, push/pop, flush on rst).

Test Plan:
- Full frame, SIZE=4, base_addr=100, res_data=p, mem_ready=1 -> 16 writes addr 100..115, data 0..15, done exactly 1 cycle after last write, sat_count=0.
- Saturation: res_data = 2^40, -2^40, -5 with relu_en=0 -> wdata 32'h7FFFFFFF, 32'h80000000, -5; sat_count=2. Same inputs with relu_en=1 -> 7FFFFFFF, 0, 0; sat_count=1.
- Back-pressure: mem_ready=0 for 5 cycles mid-frame -> res_ready drops after 2 accepts; mem_addr/mem_wdata stable; no loss on resume; order preserved.
- Address wrap: ADDR_W=16, base_addr=16'hFFFE, SIZE=2 -> addrs FFFE, FFFF, 0000, 0001.
- Reset mid-frame after 5 accepts -> next cycle all outputs 0, no done; a new start then writes a full clean frame from p=0.
- start pulsed during RUN -> ignored; base unchanged; exactly SIZE*SIZE writes and a single done.
